// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/load-store memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;

  // Watchdog defaults: 256-cycle abort needs a 9-bit counter.
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 256;
  localparam int unsigned DEFAULT_TO_WIDTH       = 9;

  // Arbiter states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } arb_state_t;

  // Which requester was granted most recently.
  typedef enum logic {
    LAST_I = 1'b0,
    LAST_D = 1'b1
  } last_t;

  // Command presented on the memory bus for one transaction.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } bus_cmd_t;

  // Fetches are plain reads: no write data, no byte enables.
  function automatic bus_cmd_t fetch_cmd(input logic [ADDR_W-1:0] addr);
    bus_cmd_t cmd;
    cmd.addr  = addr;
    cmd.we    = 1'b0;
    cmd.wdata = '0;
    cmd.wmask = '0;
    return cmd;
  endfunction

  // Loads drive an all-zero byte-enable mask on the bus.
  function automatic bus_cmd_t data_cmd(input logic [ADDR_W-1:0] addr,
                                        input logic              we,
                                        input logic [DATA_W-1:0] wdata,
                                        input logic [MASK_W-1:0] wmask);
    bus_cmd_t cmd;
    cmd.addr  = addr;
    cmd.we    = we;
    cmd.wdata = wdata;
    cmd.wmask = we ? wmask : '0;
    return cmd;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-bus signals around the arbiter.
interface mem_port_arbiter_if;
  import mem_port_arbiter_pkg::*;

  // Instruction-fetch requester
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic [DATA_W-1:0] i_rdata;
  logic              i_err;

  // Load/store requester
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_we;
  logic [DATA_W-1:0] d_wdata;
  logic [MASK_W-1:0] d_wmask;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;

  // Shared memory bus
  logic              m_req;
  logic [ADDR_W-1:0] m_addr;
  logic              m_we;
  logic [DATA_W-1:0] m_wdata;
  logic [MASK_W-1:0] m_wmask;
  logic              m_ack;
  logic [DATA_W-1:0] m_rdata;

  // Arbiter side: owns the memory bus and answers both requesters.
  modport master (
    input  i_req, i_addr,
    input  d_req, d_addr, d_we, d_wdata, d_wmask,
    input  m_ack, m_rdata,
    output i_ack, i_rdata, i_err,
    output d_ack, d_rdata, d_err,
    output m_req, m_addr, m_we, m_wdata, m_wmask
  );

  // Environment side: requesters plus the memory.
  modport slave (
    output i_req, i_addr,
    output d_req, d_addr, d_we, d_wdata, d_wmask,
    output m_ack, m_rdata,
    input  i_ack, i_rdata, i_err,
    input  d_ack, d_rdata, d_err,
    input  m_req, m_addr, m_we, m_wdata, m_wmask
  );

endinterface

// File: rtl/mem_port_arbiter_bus_watchdog.sv
// Counts unacknowledged bus cycles and flags when a transaction must be aborted.
module mem_port_arbiter_bus_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TO_WIDTH       = 9
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire_c
);

  // Last cycle index before the abort; unused when the watchdog is disabled.
  localparam logic [TO_WIDTH-1:0] LIMIT =
    TO_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [TO_WIDTH-1:0] count_q;

  // Cycle counter: cleared at grant, advanced on each wait cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable) begin
      count_q <= count_q + TO_WIDTH'(1);
    end
  end

  // A zero timeout disables the abort entirely.
  assign expire_c = (TIMEOUT_CYCLES != 0) && (count_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory bus between fetch (I) and load/store (D),
// one transaction in flight, with a watchdog that aborts unacknowledged transactions.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned TO_WIDTH       = DEFAULT_TO_WIDTH
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.master bus
);

  arb_state_t        state_q, state_d;
  last_t             last_q, last_d;
  bus_cmd_t          cmd_q, cmd_d;
  logic              m_req_q, m_req_d;

  logic              i_ack_q, i_ack_d;
  logic              i_err_q, i_err_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic              d_ack_q, d_ack_d;
  logic              d_err_q, d_err_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic              wd_clear;
  logic              wd_enable;
  logic              wd_expire_c;
  logic              i_elig_c;
  logic              d_elig_c;

  // A requester whose ACK is showing still has its old REQ up; ignore it this cycle.
  assign i_elig_c = bus.i_req && !i_ack_q;
  assign d_elig_c = bus.d_req && !d_ack_q;

  mem_port_arbiter_bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TO_WIDTH       (TO_WIDTH)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (wd_clear),
    .enable   (wd_enable),
    .expire_c (wd_expire_c)
  );

  // Next-state, grant selection and response generation.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cmd_d     = cmd_q;
    m_req_d   = m_req_q;
    i_ack_d   = 1'b0;
    i_err_d   = 1'b0;
    i_rdata_d = '0;
    d_ack_d   = 1'b0;
    d_err_d   = 1'b0;
    d_rdata_d = '0;
    wd_clear  = 1'b0;
    wd_enable = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // D wins a conflict unless it was granted last.
        if (d_elig_c && (!i_elig_c || (last_q == LAST_I))) begin
          cmd_d    = data_cmd(bus.d_addr, bus.d_we, bus.d_wdata, bus.d_wmask);
          last_d   = LAST_D;
          state_d  = ST_BUSY_D;
          m_req_d  = 1'b1;
          wd_clear = 1'b1;
        end else if (i_elig_c) begin
          cmd_d    = fetch_cmd(bus.i_addr);
          last_d   = LAST_I;
          state_d  = ST_BUSY_I;
          m_req_d  = 1'b1;
          wd_clear = 1'b1;
        end
      end

      ST_BUSY_I, ST_BUSY_D: begin
        // An ACK in the expiry cycle still completes normally.
        if (bus.m_ack) begin
          state_d = ST_IDLE;
          m_req_d = 1'b0;
          if (state_q == ST_BUSY_I) begin
            i_ack_d   = 1'b1;
            i_rdata_d = bus.m_rdata;
          end else begin
            d_ack_d   = 1'b1;
            d_rdata_d = bus.m_rdata;
          end
        end else if (wd_expire_c) begin
          state_d = ST_IDLE;
          m_req_d = 1'b0;
          if (state_q == ST_BUSY_I) begin
            i_ack_d = 1'b1;
            i_err_d = 1'b1;
          end else begin
            d_ack_d = 1'b1;
            d_err_d = 1'b1;
          end
        end else begin
          wd_enable = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        m_req_d = 1'b0;
      end
    endcase
  end

  // State, priority, bus command and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_q    <= LAST_I;
      cmd_q     <= '0;
      m_req_q   <= 1'b0;
      i_ack_q   <= 1'b0;
      i_err_q   <= 1'b0;
      i_rdata_q <= '0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      cmd_q     <= cmd_d;
      m_req_q   <= m_req_d;
      i_ack_q   <= i_ack_d;
      i_err_q   <= i_err_d;
      i_rdata_q <= i_rdata_d;
      d_ack_q   <= d_ack_d;
      d_err_q   <= d_err_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_addr  = cmd_q.addr;
  assign bus.m_we    = cmd_q.we;
  assign bus.m_wdata = cmd_q.wdata;
  assign bus.m_wmask = cmd_q.wmask;

  assign bus.i_ack   = i_ack_q;
  assign bus.i_err   = i_err_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_ack   = d_ack_q;
  assign bus.d_err   = d_err_q;
  assign bus.d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int unsigned TO    = 8;
  localparam int          NEVER = 1000;

  logic clk = 1'b0;
  logic rst;

  mem_port_arbiter_if bif();

  mem_port_arbiter #(
    .TIMEOUT_CYCLES (TO),
    .TO_WIDTH       (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: who owns the bus, which bus cycle it is in, fairness memory.
  int          own;          // 0 none, 1 fetch, 2 data
  int unsigned bus_cycles;
  bit          d_was_last;
  logic [31:0] t_addr, t_wdata;
  logic        t_we;
  logic [3:0]  t_wmask;
  logic        exp_m_req;
  logic        exp_i_ack, exp_i_err, exp_d_ack, exp_d_err;
  logic [31:0] exp_i_rdata, exp_d_rdata;

  // Environment: requesters and memory.
  int          i_jobs, d_jobs;
  bit          auto_fields;
  int          gap_pct;
  int          mem_wait_cfg;
  bit          mem_busy;
  int          mem_left;
  logic [31:0] mem [logic [31:0]];

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic [191:0] outs();
    return 192'({bif.m_req, bif.m_addr, bif.m_we, bif.m_wdata, bif.m_wmask,
                 bif.i_ack, bif.i_err, bif.i_rdata, bif.d_ack, bif.d_err, bif.d_rdata});
  endfunction

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic mem_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    logic [31:0] cur;
    cur = mem_read(a);
    for (int b = 0; b < 4; b++)
      if (m[b]) cur[8*b +: 8] = d[8*b +: 8];
    mem[a] = cur;
  endtask

  function automatic int next_wait();
    if (mem_wait_cfg >= 0) return mem_wait_cfg;
    if ($urandom_range(0, 7) == 0) return 12;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic model_reset();
    own = 0; bus_cycles = 0; d_was_last = 1'b0;
    t_addr = '0; t_wdata = '0; t_we = 1'b0; t_wmask = '0;
    exp_m_req = 1'b0;
    exp_i_ack = 1'b0; exp_i_err = 1'b0; exp_i_rdata = '0;
    exp_d_ack = 1'b0; exp_d_err = 1'b0; exp_d_rdata = '0;
  endtask

  // Memory answers after a per-transaction number of wait cycles.
  task automatic drive_memory();
    bif.m_ack   = 1'b0;
    bif.m_rdata = $urandom;
    if (!bif.m_req) begin
      mem_busy = 1'b0;
    end else begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_left = next_wait();
      end
      if (mem_left == 0) begin
        bif.m_ack = 1'b1;
        mem_busy  = 1'b0;
        if (bif.m_we) mem_write(bif.m_addr, bif.m_wdata, bif.m_wmask);
        else bif.m_rdata = mem_read(bif.m_addr);
      end else begin
        mem_left--;
      end
    end
  endtask

  // Requesters hold REQ until their ACK and keep it up through the ACK cycle.
  task automatic drive_requesters();
    if (bif.i_req && bif.i_ack) begin
      if (i_jobs > 0) i_jobs--;
      if (i_jobs > 0 && auto_fields) bif.i_addr = 32'h1000 + 32'(4 * $urandom_range(0, 15));
    end else if (!bif.i_req && i_jobs > 0 && int'($urandom_range(0, 99)) >= gap_pct) begin
      bif.i_req = 1'b1;
      if (auto_fields) bif.i_addr = 32'h1000 + 32'(4 * $urandom_range(0, 15));
    end else if (bif.i_req && i_jobs == 0) begin
      bif.i_req = 1'b0;
    end

    if (bif.d_req && bif.d_ack) begin
      if (d_jobs > 0) d_jobs--;
    end else if (!bif.d_req && d_jobs > 0 && int'($urandom_range(0, 99)) >= gap_pct) begin
      bif.d_req = 1'b1;
      if (auto_fields) begin
        bif.d_addr  = 32'h2000 + 32'(4 * $urandom_range(0, 15));
        bif.d_we    = 1'($urandom_range(0, 1));
        bif.d_wdata = $urandom;
        bif.d_wmask = 4'($urandom_range(0, 15));
      end
    end else if (bif.d_req && d_jobs == 0) begin
      bif.d_req = 1'b0;
    end
  endtask

  // One bus transaction at a time; round-robin on conflict; abort after TO bus cycles.
  task automatic model_step();
    logic        n_i_ack, n_i_err, n_d_ack, n_d_err;
    logic [31:0] n_i_rdata, n_d_rdata;
    bit          want_i, want_d, pick_d;
    n_i_ack = 1'b0; n_i_err = 1'b0; n_i_rdata = '0;
    n_d_ack = 1'b0; n_d_err = 1'b0; n_d_rdata = '0;
    if (own != 0) begin
      if (bif.m_ack) begin
        if (own == 1) begin n_i_ack = 1'b1; n_i_rdata = bif.m_rdata; end
        else begin n_d_ack = 1'b1; n_d_rdata = bif.m_rdata; end
        own = 0;
      end else if (TO != 0 && bus_cycles == TO) begin
        if (own == 1) begin n_i_ack = 1'b1; n_i_err = 1'b1; end
        else begin n_d_ack = 1'b1; n_d_err = 1'b1; end
        own = 0;
      end else begin
        bus_cycles++;
      end
    end else begin
      want_i = bif.i_req && !exp_i_ack;
      want_d = bif.d_req && !exp_d_ack;
      if (want_i || want_d) begin
        pick_d = want_d && !(want_i && d_was_last);
        if (pick_d) begin
          t_addr = bif.d_addr; t_we = bif.d_we; t_wdata = bif.d_wdata;
          t_wmask = bif.d_we ? bif.d_wmask : 4'h0;
          own = 2;
        end else begin
          t_addr = bif.i_addr; t_we = 1'b0; t_wdata = '0; t_wmask = 4'h0;
          own = 1;
        end
        d_was_last = pick_d;
        bus_cycles = 1;
      end
    end
    exp_m_req   = (own != 0);
    exp_i_ack   = n_i_ack; exp_i_err = n_i_err; exp_i_rdata = n_i_rdata;
    exp_d_ack   = n_d_ack; exp_d_err = n_d_err; exp_d_rdata = n_d_rdata;
  endtask

  // One clock: compare at the falling edge, then drive inputs and advance the model.
  task automatic cycle();
    @(negedge clk);
    chk("bus_req", 192'(bif.m_req), 192'(exp_m_req));
    if (exp_m_req)
      chk("bus_cmd", 192'({bif.m_addr, bif.m_we, bif.m_wdata, bif.m_wmask}),
                     192'({t_addr, t_we, t_wdata, t_wmask}));
    chk("i_resp", 192'({bif.i_ack, bif.i_err, bif.i_rdata}), 192'({exp_i_ack, exp_i_err, exp_i_rdata}));
    chk("d_resp", 192'({bif.d_ack, bif.d_err, bif.d_rdata}), 192'({exp_d_ack, exp_d_err, exp_d_rdata}));
    drive_memory();
    drive_requesters();
    model_step();
  endtask

  function automatic bit quiet();
    return own == 0 && !exp_i_ack && !exp_d_ack && i_jobs == 0 && d_jobs == 0 &&
           !bif.i_req && !bif.d_req;
  endfunction

  task automatic run_until_idle(input int budget);
    for (int n = 0; n < budget && !quiet(); n++) cycle();
    if (!quiet()) chk("idle_budget", 192'(0), 192'(1));
  endtask

  task automatic wait_m_req(input int budget);
    for (int n = 0; n < budget && !bif.m_req; n++) cycle();
    if (!bif.m_req) chk("m_req_budget", 192'(0), 192'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bif.i_req = 1'b0; bif.i_addr = '0;
    bif.d_req = 1'b0; bif.d_addr = '0; bif.d_we = 1'b0; bif.d_wdata = '0; bif.d_wmask = '0;
    bif.m_ack = 1'b0; bif.m_rdata = '0;
    i_jobs = 0; d_jobs = 0; mem_busy = 1'b0; mem_left = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_outputs", outs(), '0);
    rst = 1'b0;
  endtask

  int   n_hi;
  logic prev_mreq;
  logic [7:0] order;
  int   n_order;

  initial begin
    auto_fields = 1'b0; gap_pct = 0; mem_wait_cfg = 0;
    mem[32'h100] = 32'h0000_0013;
    do_reset();

    // Single zero-wait fetch.
    bif.i_addr = 32'h100; i_jobs = 1;
    cycle();
    cycle();
    chk("t1_bus", 192'({bif.m_req, bif.m_addr, bif.m_we, bif.m_wmask}), 192'({1'b1, 32'h100, 1'b0, 4'h0}));
    cycle();
    chk("t1_resp", 192'({bif.i_ack, bif.i_err, bif.i_rdata}), 192'({1'b1, 1'b0, 32'h13}));
    run_until_idle(20);

    // Store with two wait states: command stable over three bus cycles.
    mem_wait_cfg = 2;
    bif.d_addr = 32'h2004; bif.d_we = 1'b1; bif.d_wdata = 32'hDEAD_BEEF; bif.d_wmask = 4'b0011;
    d_jobs = 1;
    cycle();
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("t2_stable", 192'({bif.m_req, bif.m_addr, bif.m_we, bif.m_wdata, bif.m_wmask, bif.d_ack}),
                       192'({1'b1, 32'h2004, 1'b1, 32'hDEAD_BEEF, 4'b0011, 1'b0}));
    end
    cycle();
    chk("t2_ack", 192'({bif.d_ack, bif.d_err, bif.m_req, bif.i_ack}), 192'({1'b1, 1'b0, 1'b0, 1'b0}));
    run_until_idle(20);

    // Contention straight after reset: D first, then strict alternation.
    do_reset();
    auto_fields = 1'b1; mem_wait_cfg = 0; i_jobs = 4; d_jobs = 4;
    prev_mreq = 1'b0; order = '0; n_order = 0;
    for (int n = 0; n < 60 && !quiet(); n++) begin
      cycle();
      if (bif.m_req && !prev_mreq && n_order < 8) begin
        order = {order[6:0], bif.m_addr[13]};
        n_order++;
      end
      prev_mreq = bif.m_req;
    end
    chk("t3_order", 192'(order), 192'(8'b1010_1010));
    chk("t3_count", 192'(n_order), 192'(8));
    run_until_idle(20);

    // Timeout: memory never answers; a fetch queues behind the load.
    auto_fields = 1'b0; mem_wait_cfg = NEVER;
    bif.d_addr = 32'h2040; bif.d_we = 1'b0; bif.d_wdata = 32'h0; bif.d_wmask = 4'hF;
    bif.i_addr = 32'h1010;
    d_jobs = 1;
    cycle();
    n_hi = 0;
    for (int n = 0; n < 20 && !bif.d_ack; n++) begin
      cycle();
      if (bif.m_req) n_hi++;
      if (n == 2) i_jobs = 1;
    end
    chk("t4_req_cycles", 192'(n_hi), 192'(TO));
    chk("t4_abort", 192'({bif.d_ack, bif.d_err, bif.d_rdata}), 192'({1'b1, 1'b1, 32'h0}));
    mem_wait_cfg = 0;
    cycle();
    chk("t4_i_granted", 192'({bif.m_req, bif.m_addr}), 192'({1'b1, 32'h1010}));
    run_until_idle(20);

    // ACK on the last allowed cycle completes without error.
    mem_wait_cfg = TO - 1; d_jobs = 1;
    cycle();
    n_hi = 0;
    for (int n = 0; n < 20 && !bif.d_ack; n++) begin
      cycle();
      if (bif.m_req) n_hi++;
    end
    chk("t4b_req_cycles", 192'(n_hi), 192'(TO));
    chk("t4b_resp", 192'({bif.d_ack, bif.d_err, bif.d_rdata}), 192'({1'b1, 1'b0, mem_read(32'h2040)}));
    run_until_idle(20);

    // Held REQ through its ACK: skipped that cycle, regranted the next.
    mem_wait_cfg = 0; bif.i_addr = 32'h100; i_jobs = 2;
    cycle();
    cycle();
    cycle();
    chk("t6_ack", 192'({bif.i_ack, bif.i_req, bif.i_rdata}), 192'({1'b1, 1'b1, 32'h13}));
    cycle();
    chk("t6_no_grant", 192'(bif.m_req), 192'(0));
    cycle();
    chk("t6_regrant", 192'({bif.m_req, bif.m_addr}), 192'({1'b1, 32'h100}));
    run_until_idle(20);

    // Reset in the middle of a fetch clears everything without a clock edge.
    mem_wait_cfg = NEVER; bif.i_addr = 32'h300; i_jobs = 1;
    wait_m_req(6);
    #2 rst = 1'b1;
    #1 chk("async_reset", outs(), '0);
    do_reset();
    auto_fields = 1'b1; mem_wait_cfg = 0; d_jobs = 1;
    wait_m_req(6);
    chk("t5_d_first", 192'({bif.m_req, bif.m_addr[13]}), 192'({1'b1, 1'b1}));
    run_until_idle(20);

    // Randomized traffic with random wait states and occasional timeouts.
    mem_wait_cfg = -1; gap_pct = 40; i_jobs = 40; d_jobs = 40;
    run_until_idle(4000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-ported memory bus between the core's instruction-fetch requester (I, read-only) and its load/store requester (D, read/write). Only one transaction is outstanding at a time; when both requesters are pending, grants alternate round-robin. A watchdog aborts any bus transaction the memory never acknowledges and returns an access error to the requester. It sits between the fetch/load-store logic driven by the instruction decoder and the external memory interface.

Parameters:
TIMEOUT_CYCLES, 256, cycles M_REQ may stay high without M_ACK before abort; 0 disables the watchdog
TO_WIDTH, 9, counter width; must satisfy 2^TO_WIDTH > TIMEOUT_CYCLES

Ports:
CLK  in  1  single clock, rising edge
RESET  in  1  asynchronous, active-high reset
I_REQ  in  1  fetch request; held until I_ACK
I_ADDR  in  32  fetch address
I_ACK  out  1  one-cycle pulse: fetch complete
I_RDATA  out  32  fetch data; valid while I_ACK=1
I_ERR  out  1  fetch aborted by timeout; valid with I_ACK
D_REQ  in  1  data request; held until D_ACK
D_ADDR  in  32  data address
D_WE  in  1  1=store, 0=load
D_WDATA  in  32  store data
D_WMASK  in  4  store byte enables
D_ACK  out  1  one-cycle pulse: data access complete
D_RDATA  out  32  load data; valid while D_ACK=1
D_ERR  out  1  data access aborted by timeout; valid with D_ACK
M_REQ  out  1  bus request; held until M_ACK
M_ADDR  out  32  bus address
M_WE  out  1  bus write
M_WDATA  out  32  bus write data
M_WMASK  out  4  bus byte enables; 4'b0000 for reads
M_ACK  in  1  bus done; sampled only while M_REQ=1
M_RDATA  in  32  bus read data; valid with M_ACK

Behaviour:
- Interface is fixed as: one clock CLK; RESET asynchronous, active-high.
- States: IDLE, BUSY_I, BUSY_D. Priority flag LAST (0=I last, 1=D last).
- Reset: state IDLE, LAST=0 (D wins first conflict), watchdog=0, all outputs 0.
- IDLE at cycle t, a requester eligible:
  - Only one eligible: grant it.
  - Both eligible: grant the one not equal to LAST.
  - Grant effects: latch addr/we/wdata/wmask (I: we=0, mask=0); LAST <= granted; state <= BUSY_x.
  - At t+1: M_REQ=1 with latched fields.
- Eligibility: a requester is ineligible in the cycle its own ACK is high. This prevents re-issuing a request whose REQ is still high. The other requester may be granted in that cycle.
- BUSY_x, M_ACK=1:
  - State <= IDLE; M_REQ <= 0.
  - Next cycle: x_ACK=1, x_RDATA = M_RDATA captured at the ack edge (stores return the captured value; do not rely on it); x_ERR=0.
- Timing:
  - Minimum latency REQ→ACK is 3 cycles (zero-wait memory: grant t, M_REQ t+1 with M_ACK, x_ACK t+2).
  - Back-to-back throughput: 1 transaction per 2 cycles across requesters.
- Watchdog:
  - Cleared on grant; increments each BUSY cycle without M_ACK.
  - If it reaches TIMEOUT_CYCLES-1 with no M_ACK and TIMEOUT_CYCLES≠0: state <= IDLE, M_REQ <= 0; next cycle x_ACK=1, x_ERR=1, x_RDATA=0.
  - M_ACK in that same cycle wins: normal completion, no error.
- Outputs:
  - All outputs are registered.
  - ACK/ERR are single-cycle pulses; RDATA holds 0 when ACK=0.
  - M_* fields stay stable for the whole M_REQ assertion.
- Requester misbehaviour: dropping x_REQ while BUSY_x does not cancel the bus transaction; x_ACK still pulses.
- Reset mid-transaction: everything returns to reset values immediately; the bus transaction is abandoned.

Decomposition:
- Shared header globals.vh: state encodings (IDLE/BUSY_I/BUSY_D) and a default-timeout constant.
- One natural sub-module, bus_watchdog: counter with clear/enable/expire, parameterised by TIMEOUT_CYCLES and TO_WIDTH. The FSM, round-robin logic and registers stay in mem_port_arbiter.

Test Plan:
1. Single fetch: I_REQ, I_ADDR=0x100; memory ACKs in the first M_REQ cycle with 0x00000013 -> M_REQ at t+1 with M_ADDR=0x100, M_WMASK=0; I_ACK at t+2 with I_RDATA=0x13, I_ERR=0.
2. Store with 2 wait states: D_WE=1, D_ADDR=0x2004, D_WDATA=0xDEADBEEF, D_WMASK=4'b0011 -> M_* stable for 3 cycles; D_ACK one cycle after M_ACK; no I activity.
3. Simultaneous contention: I_REQ and D_REQ held for 4 transactions each after reset -> bus order D,I,D,I,...; no requester is starved; every ACK goes to the correct requester.
4. Timeout: TIMEOUT_CYCLES=8, M_ACK never asserted -> M_REQ high exactly 8 cycles, then D_ACK=1, D_ERR=1, D_RDATA=0; a queued I request is granted in the D_ACK cycle. Variant with M_ACK on the 8th cycle -> D_ERR=0.
5. Reset mid-transaction: assert RESET while BUSY_I with M_REQ=1 -> all outputs 0 asynchronously; after release with only D_REQ pending, D is granted first.
6. Held REQ after ACK: requester keeps I_REQ high through the I_ACK cycle with no new intent -> no grant in that cycle; a new grant occurs the following cycle (verifies the eligibility rule).
